// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of a single picorv32-style mem_* port.
// Port 0 (CPU) and port 1 (DMA/video) share the sdram wrapper; a watchdog
// force-completes any access the wrapper never acknowledges.
module sdram_arbiter #(
   parameter int unsigned FIXED_PRIORITY = 0,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        mem_valid,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err,
   output logic [7:0]  timeout_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] WDOG_LAST = WDOG_EN ? 32'(TIMEOUT_CYCLES - 1) : '0;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [31:0] wdog_q, wdog_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        in_grant;
   logic        own_valid;
   logic [3:0]  own_wstrb;
   logic [31:0] own_addr;
   logic [31:0] own_wdata;
   logic        forced;

   // Select the current owner's request fields; port 0 is the idle default.
   always_comb begin
      in_grant  = (state_q == G0) || (state_q == G1);
      own_valid = m0_valid;
      own_wstrb = m0_wstrb;
      own_addr  = m0_addr;
      own_wdata = m0_wdata;
      if (state_q == G1) begin
         own_valid = m1_valid;
         own_wstrb = m1_wstrb;
         own_addr  = m1_addr;
         own_wdata = m1_wdata;
      end
      // A real ack in the expiry cycle wins, and a dropped request is an abort.
      forced = WDOG_EN && in_grant && own_valid && !mem_ready && (wdog_q == WDOG_LAST);
   end

   // Drive the downstream port and the per-master completion pulses.
   always_comb begin
      mem_valid   = in_grant && own_valid;
      mem_wstrb   = own_wstrb;
      mem_addr    = own_addr;
      mem_wdata   = own_wdata;
      m0_ready    = (state_q == G0) && (mem_ready || forced);
      m1_ready    = (state_q == G1) && (mem_ready || forced);
      m0_rdata    = forced ? TIMEOUT_RDATA : mem_rdata;
      m1_rdata    = forced ? TIMEOUT_RDATA : mem_rdata;
      grant       = {state_q == G1, state_q == G0};
      timeout_err = err_q;
      timeout_cnt = cnt_q;
   end

   // Next-state: arbitration in IDLE, completion/abort/watchdog in a grant state.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (m0_valid && m1_valid) begin
               if (FIXED_PRIORITY != 0) state_d = G0;
               else                     state_d = last_q ? G0 : G1;
            end else if (m0_valid) begin
               state_d = G0;
            end else if (m1_valid) begin
               state_d = G1;
            end
         end
         G0, G1: begin
            wdog_d = 32'(wdog_q + 32'd1);
            if (mem_ready) begin
               last_d  = (state_q == G1);
               state_d = IDLE;
            end else if (!own_valid) begin
               state_d = IDLE;
            end else if (forced) begin
               last_d  = (state_q == G1);
               state_d = IDLE;
               err_d   = 1'b1;
               cnt_d   = (cnt_q == 8'hFF) ? cnt_q : 8'(cnt_q + 8'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; last=1 so port 0 is served first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wdog_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus pushes expected completions,
// a monitor pops them whenever a master sees ready.
module tb_sdram_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        m0_valid, m1_valid;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_valid;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [1:0]  grant;
   logic        timeout_err;
   logic [7:0]  timeout_cnt;

   logic        b_m0_valid, b_m1_valid;
   logic [31:0] b_m0_addr, b_m1_addr;
   logic        b_m0_ready, b_m1_ready;
   logic [31:0] b_m0_rdata, b_m1_rdata;
   logic        b_mem_valid;
   logic [3:0]  b_mem_wstrb;
   logic [31:0] b_mem_addr, b_mem_wdata;
   logic        b_mem_ready;
   logic [31:0] b_mem_rdata;
   logic [1:0]  b_grant;
   logic        b_timeout_err;
   logic [7:0]  b_timeout_cnt;

   sdram_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .mem_valid(mem_valid), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant(grant), .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
   );

   sdram_arbiter #(.FIXED_PRIORITY(1)) dut_b (
      .clk(clk), .reset(reset),
      .m0_valid(b_m0_valid), .m0_wstrb(4'b0000), .m0_addr(b_m0_addr), .m0_wdata(32'h0),
      .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
      .m1_valid(b_m1_valid), .m1_wstrb(4'b0000), .m1_addr(b_m1_addr), .m1_wdata(32'h0),
      .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
      .mem_valid(b_mem_valid), .mem_wstrb(b_mem_wstrb), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
      .grant(b_grant), .timeout_err(b_timeout_err), .timeout_cnt(b_timeout_cnt)
   );

   // Second wrapper acks on the first grant cycle and returns the address as data.
   assign b_mem_ready = b_mem_valid;
   assign b_mem_rdata = b_mem_addr;

   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t expb_q[$];
   exp_t mon_e;
   exp_t mon_eb;
   int   checks = 0;
   int   errors = 0;

   int unsigned resp_lat  = 0;
   logic [31:0] resp_data = '0;
   logic        stale_ack = 1'b0;
   int unsigned rcnt      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Model of the sdram wrapper: acks after resp_lat cycles of mem_valid (0 = never).
   always @(negedge clk) begin
      if (mem_valid) rcnt = rcnt + 1;
      else           rcnt = 0;
      mem_ready = stale_ack || (mem_valid && resp_lat != 0 && rcnt == resp_lat);
      mem_rdata = resp_data;
   end

   // Monitor: every ready must match the next expected completion.
   always @(negedge clk) begin
      #2;
      if (m0_ready || m1_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready actual=m0:%b m1:%b required=none", m0_ready, m1_ready);
         end else begin
            mon_e = exp_q.pop_front();
            check("ready_port", {30'b0, m0_ready, m1_ready}, mon_e.port ? 32'd1 : 32'd2);
            check("rdata", mon_e.port ? m1_rdata : m0_rdata, mon_e.data);
         end
      end
      if (b_m0_ready || b_m1_ready) begin
         if (expb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready_b actual=m0:%b m1:%b required=none", b_m0_ready, b_m1_ready);
         end else begin
            mon_eb = expb_q.pop_front();
            check("b_ready_port", {30'b0, b_m0_ready, b_m1_ready}, mon_eb.port ? 32'd1 : 32'd2);
            check("b_rdata", mon_eb.port ? b_m1_rdata : b_m0_rdata, mon_eb.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #3;
   endtask

   task automatic push(input logic port, input logic [31:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Wait for a ready on the given port, counting cycles with a non-idle grant.
   task automatic wait_ready(input logic port, input int maxc, output int gcyc);
      logic got;
      got  = 1'b0;
      gcyc = 0;
      for (int i = 0; i < maxc && !got; i++) begin
         sample();
         if (grant != 2'b00) gcyc++;
         if (port ? m1_ready : m0_ready) got = 1'b1;
      end
      check(port ? "ready_seen_p1" : "ready_seen_p0", {31'b0, got}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int   g;
      int   n;
      logic prev;
      exp_t eb;

      reset = 1'b1;
      m0_valid = 1'b0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
      m1_valid = 1'b0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
      b_m0_valid = 1'b0; b_m1_valid = 1'b0; b_m0_addr = '0; b_m1_addr = '0;
      repeat (3) step();
      sample();
      check("rst_grant", {30'b0, grant}, 32'd0);
      check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("rst_ready", {30'b0, m0_ready, m1_ready}, 32'd0);
      check("rst_err", {31'b0, timeout_err}, 32'd0);
      check("rst_cnt", {24'b0, timeout_cnt}, 32'd0);
      step();
      reset = 1'b0;

      // Single read on port 0, six-cycle wrapper latency.
      step();
      m0_valid = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'b0000;
      resp_lat = 6; resp_data = 32'h1234_5678;
      push(1'b0, 32'h1234_5678);
      wait_ready(1'b0, 40, g);
      check("t1_grant_cycles", g, 32'd6);
      step();
      m0_valid = 1'b0;

      // Port 1 write mirrored onto mem_*.
      step();
      m1_valid = 1'b1; m1_wstrb = 4'b0011; m1_addr = 32'h100; m1_wdata = 32'hCAFE_0001;
      resp_lat = 3; resp_data = 32'hDEAD_BEEF;
      push(1'b1, 32'hDEAD_BEEF);
      sample();
      check("t5_idle_no_mem_valid", {31'b0, mem_valid}, 32'd0);
      sample();
      check("t5_grant", {30'b0, grant}, 32'd2);
      check("t5_mem_valid", {31'b0, mem_valid}, 32'd1);
      check("t5_mem_wstrb", {28'b0, mem_wstrb}, 32'h3);
      check("t5_mem_addr", mem_addr, 32'h100);
      check("t5_mem_wdata", mem_wdata, 32'hCAFE_0001);
      wait_ready(1'b1, 20, g);
      check("t5_rest_cycles", g, 32'd2);
      step();
      m1_valid = 1'b0;

      // Both ports continuously valid, round-robin: 0,1,0,1 with an idle gap.
      step();
      m0_valid = 1'b1; m1_valid = 1'b1; m0_wstrb = '0; m1_wstrb = '0;
      resp_lat = 2; resp_data = 32'h5555_AAAA;
      push(1'b0, 32'h5555_AAAA); push(1'b1, 32'h5555_AAAA);
      push(1'b0, 32'h5555_AAAA); push(1'b1, 32'h5555_AAAA);
      n = 0; prev = 1'b0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         sample();
         if (prev) check("t2_idle_gap", {30'b0, grant}, 32'd0);
         prev = m0_ready || m1_ready;
         if (prev) n++;
      end
      check("t2_served", n, 32'd4);
      step();
      m0_valid = 1'b0; m1_valid = 1'b0;

      // Wrapper never acks: forced completion on the 16th grant cycle.
      step();
      m0_valid = 1'b1; resp_lat = 0; resp_data = 32'h0;
      push(1'b0, 32'hFFFF_FFFF);
      wait_ready(1'b0, 40, g);
      check("t4_grant_cycles", g, 32'd16);
      step();
      m0_valid = 1'b0;
      sample();
      check("t4_err", {31'b0, timeout_err}, 32'd1);
      check("t4_cnt", {24'b0, timeout_cnt}, 32'd1);
      step();
      stale_ack = 1'b1;
      sample();
      check("t4_stale_ready", {30'b0, m0_ready, m1_ready}, 32'd0);
      check("t4_stale_grant", {30'b0, grant}, 32'd0);
      step();
      stale_ack = 1'b0;

      // Ack landing in the expiry cycle is a normal completion.
      step();
      m0_valid = 1'b1; resp_lat = 16; resp_data = 32'h0BAD_F00D;
      push(1'b0, 32'h0BAD_F00D);
      wait_ready(1'b0, 40, g);
      check("tie_grant_cycles", g, 32'd16);
      step();
      m0_valid = 1'b0;
      sample();
      check("tie_cnt", {24'b0, timeout_cnt}, 32'd1);

      // Abort on port 1: no ready, back to idle, last unchanged (still 0).
      step();
      m1_valid = 1'b1; resp_lat = 0;
      sample(); sample(); sample();
      step();
      m1_valid = 1'b0;
      sample();
      check("abort_mem_valid", {31'b0, mem_valid}, 32'd0);
      sample();
      check("abort_idle", {30'b0, grant}, 32'd0);
      step();
      m0_valid = 1'b1; m1_valid = 1'b1; resp_lat = 1; resp_data = 32'h1111_2222;
      push(1'b1, 32'h1111_2222);
      wait_ready(1'b1, 20, g);
      step();
      m0_valid = 1'b0; m1_valid = 1'b0;

      // Reset in the middle of a port 1 grant.
      step();
      m1_valid = 1'b1; resp_lat = 0;
      sample(); sample(); sample();
      check("t6_in_g1", {30'b0, grant}, 32'd2);
      step();
      reset = 1'b1;
      step();
      sample();
      check("t6_grant", {30'b0, grant}, 32'd0);
      check("t6_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("t6_err", {31'b0, timeout_err}, 32'd0);
      check("t6_cnt", {24'b0, timeout_cnt}, 32'd0);
      step();
      reset = 1'b0; m0_valid = 1'b1; resp_lat = 1; resp_data = 32'h7777_0000;
      push(1'b0, 32'h7777_0000);
      wait_ready(1'b0, 20, g);
      step();
      m0_valid = 1'b0; m1_valid = 1'b0;

      // Fixed priority instance: port 0 wins every time.
      step();
      b_m0_valid = 1'b1; b_m1_valid = 1'b1; b_m0_addr = 32'h200; b_m1_addr = 32'h300;
      eb.port = 1'b0; eb.data = 32'h200;
      repeat (4) expb_q.push_back(eb);
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         sample();
         if (b_m0_ready || b_m1_ready) n++;
      end
      check("t3_served", n, 32'd4);
      step();
      b_m0_valid = 1'b0; b_m1_valid = 1'b0;

      repeat (3) step();
      check("exp_queue_empty", exp_q.size() + expb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
